bin_to_bcd: RTL and testbench

//  Sequential double-dabble (shift-add-3) FSMD: converts an unsigned WIDTH-bit binary value to DIGITS BCD digits.

---
 rtl/bin_to_bcd_if.sv | 23 ++
 rtl/bin_to_bcd.sv | 103 ++++++++++
 tb/tb_bin_to_bcd.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_if.sv
// Start/ready/done handshake bundle for the binary-to-BCD converter.
// The master drives the operand; the slave (converter) returns digits and status.
interface bin_to_bcd_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 2
);
  logic             start;
  logic [WIDTH-1:0] bin_value;
  logic             ready;
  logic             done_tick;
  logic [3:0]       bcd_value [DIGITS];
  logic             overflow;

  modport master (
    output start, bin_value,
    input  ready, done_tick, bcd_value, overflow
  );

  modport slave (
    input  start, bin_value,
    output ready, done_tick, bcd_value, overflow
  );
endinterface

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble converter: one shift-add-3 iteration per clock.
// Results saturate to all nines with overflow set when the value needs more than DIGITS digits.
//
// state | meaning
// IDLE  | ready, waiting for start
// OP    | one adjust+shift iteration per clock, n counts down
// DONE  | single-cycle done_tick, outputs hold the new result
module bin_to_bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 2
) (
  input logic clk,
  input logic reset,
  bin_to_bcd_if.slave bus
);
  localparam int NW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, OP, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [NW-1:0]    n_q, n_d;
  logic             ovf_q, ovf_d;
  logic [BW-1:0]    out_q, out_d;
  logic             out_ovf_q, out_ovf_d;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    nines;

  // Adjusted digits are at most 12, so no carry ever crosses a digit boundary.
  always_comb begin
    adj   = '0;
    nines = '0;
    for (int i = 0; i < DIGITS; i++) begin
      adj[4*i +: 4]   = (bcd_q[4*i +: 4] > 4'd4) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
      nines[4*i +: 4] = 4'd9;
    end
  end

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    n_d       = n_q;
    ovf_d     = ovf_q;
    out_d     = out_q;
    out_ovf_d = out_ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          bin_d   = bus.bin_value;
          bcd_d   = '0;
          n_d     = NW'(WIDTH);
          ovf_d   = 1'b0;
          state_d = OP;
        end
      end
      OP: begin
        // The bit leaving the top digit means the value no longer fits.
        ovf_d = ovf_q | adj[BW-1];
        bcd_d = {adj[BW-2:0], bin_q[WIDTH-1]};
        bin_d = bin_q << 1;
        n_d   = n_q - 1'b1;
        if (n_q == NW'(1)) begin
          out_d     = ovf_d ? nines : bcd_d;
          out_ovf_d = ovf_d;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      n_q       <= '0;
      ovf_q     <= 1'b0;
      out_q     <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      n_q       <= n_d;
      ovf_q     <= ovf_d;
      out_q     <= out_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign bus.ready     = (state_q == IDLE);
  assign bus.done_tick = (state_q == DONE);
  assign bus.overflow  = out_ovf_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign bus.bcd_value[g] = out_q[4*g +: 4];
  end
endmodule

// File: tb/tb_bin_to_bcd.sv
// Bench for bin_to_bcd: a 2-digit and a 3-digit instance, expected results queued
// at stimulus time and compared when done_tick appears.
module tb_bin_to_bcd;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bin_to_bcd_if #(.WIDTH(8), .DIGITS(2)) bus2 ();
  bin_to_bcd_if #(.WIDTH(8), .DIGITS(3)) bus3 ();

  bin_to_bcd #(.WIDTH(8), .DIGITS(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
  bin_to_bcd #(.WIDTH(8), .DIGITS(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  typedef struct {
    logic [11:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic exp_t model(int v, int digits);
    exp_t e;
    int   t;
    int   lim;
    lim   = (digits == 3) ? 999 : 99;
    e.bcd = '0;
    e.ovf = 1'b0;
    t     = v;
    if (v > lim) begin
      e.ovf = 1'b1;
      for (int i = 0; i < digits; i++) e.bcd[4*i +: 4] = 4'd9;
    end else begin
      for (int i = 0; i < digits; i++) begin
        e.bcd[4*i +: 4] = 4'(t % 10);
        t = t / 10;
      end
    end
    return e;
  endfunction

  function automatic logic [11:0] got_bcd(bit sel);
    if (sel) return {bus3.bcd_value[2], bus3.bcd_value[1], bus3.bcd_value[0]};
    return {4'd0, bus2.bcd_value[1], bus2.bcd_value[0]};
  endfunction

  function automatic logic got_ovf(bit sel);
    return sel ? bus3.overflow : bus2.overflow;
  endfunction

  function automatic logic got_done(bit sel);
    return sel ? bus3.done_tick : bus2.done_tick;
  endfunction

  function automatic logic got_ready(bit sel);
    return sel ? bus3.ready : bus2.ready;
  endfunction

  task automatic drive(input bit sel, input logic s, input logic [7:0] v);
    if (sel) begin
      bus3.start     = s;
      bus3.bin_value = v;
    end else begin
      bus2.start     = s;
      bus2.bin_value = v;
    end
  endtask

  // Drives one accepted start and returns #1 after the edge where done_tick rose.
  task automatic run_conv(input bit sel, input int v, output int lat, output bit seen);
    seen = 1'b0;
    lat  = 0;
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      if (got_ready(sel)) break;
      @(negedge clk);
    end
    drive(sel, 1'b1, 8'(v));
    sb_q.push_back(model(v, sel ? 3 : 2));
    @(posedge clk);
    @(negedge clk);
    drive(sel, 1'b0, 8'(v));
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (got_done(sel)) begin
        lat  = k;
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bit done_seen;
    reset = 1'b1;
    drive(0, 1'b0, 8'd0);
    drive(1, 1'b0, 8'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus2.done_tick) done_seen = 1'b1;
    end
    n_checks++;
    if (bus2.ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", bus2.ready);
    else n_pass++;
    n_checks++;
    if (got_bcd(0) !== 12'h000) $display("FAIL reset_bcd: got %h expected 000", got_bcd(0));
    else n_pass++;
    n_checks++;
    if (bus2.overflow !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", bus2.overflow);
    else n_pass++;
    n_checks++;
    if (done_seen !== 1'b0) $display("FAIL reset_done: got %b expected 0", done_seen);
    else n_pass++;
  endtask

  task automatic test_basic_84;
    int   lat;
    bit   seen;
    exp_t e;
    run_conv(0, 84, lat, seen);
    e = sb_q.pop_front();
    n_checks++;
    if (lat != 8) $display("FAIL basic_latency: got %0d expected 8", lat);
    else n_pass++;
    n_checks++;
    if (got_bcd(0) !== e.bcd) $display("FAIL basic_bcd: got %h expected %h", got_bcd(0), e.bcd);
    else n_pass++;
    n_checks++;
    if (bus2.overflow !== e.ovf) $display("FAIL basic_ovf: got %b expected %b", bus2.overflow, e.ovf);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus2.done_tick !== 1'b0) $display("FAIL basic_done_width: got %b expected 0", bus2.done_tick);
    else n_pass++;
    n_checks++;
    if (bus2.ready !== 1'b1) $display("FAIL basic_ready_after: got %b expected 1", bus2.ready);
    else n_pass++;
  endtask

  task automatic test_values;
    int   vals[5] = '{0, 39, 99, 100, 255};
    int   lat;
    bit   seen;
    exp_t e;
    foreach (vals[i]) begin
      run_conv(0, vals[i], lat, seen);
      e = sb_q.pop_front();
      n_checks++;
      if (!seen || got_bcd(0) !== e.bcd)
        $display("FAIL value_bcd %0d: got %h expected %h (done seen %b)", vals[i], got_bcd(0), e.bcd, seen);
      else n_pass++;
      n_checks++;
      if (bus2.overflow !== e.ovf)
        $display("FAIL value_ovf %0d: got %b expected %b", vals[i], bus2.overflow, e.ovf);
      else n_pass++;
    end
  endtask

  task automatic test_digits3;
    int   vals[2] = '{255, 100};
    int   lat;
    bit   seen;
    exp_t e;
    foreach (vals[i]) begin
      run_conv(1, vals[i], lat, seen);
      e = sb_q.pop_front();
      n_checks++;
      if (!seen || got_bcd(1) !== e.bcd)
        $display("FAIL d3_bcd %0d: got %h expected %h (done seen %b)", vals[i], got_bcd(1), e.bcd, seen);
      else n_pass++;
      n_checks++;
      if (bus3.overflow !== e.ovf) $display("FAIL d3_ovf %0d: got %b expected %b", vals[i], bus3.overflow, e.ovf);
      else n_pass++;
    end
  endtask

  task automatic test_mid_op_ignored;
    int   dones;
    exp_t e;
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      if (bus2.ready) break;
      @(negedge clk);
    end
    drive(0, 1'b1, 8'd37);
    sb_q.push_back(model(37, 2));
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 8'd37);
    dones = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) drive(0, 1'b1, 8'd80);
      if (k == 4) drive(0, 1'b0, 8'd200);
      if (bus2.done_tick) begin
        dones++;
        if (dones == 1) begin
          e = sb_q.pop_front();
          n_checks++;
          if (got_bcd(0) !== e.bcd) $display("FAIL midop_bcd: got %h expected %h", got_bcd(0), e.bcd);
          else n_pass++;
        end
      end
    end
    if (dones == 0) sb_q.delete();
    n_checks++;
    if (dones != 1) $display("FAIL midop_done_count: got %0d expected 1", dones);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    bit   done_seen;
    int   lat;
    bit   seen;
    exp_t e;
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      if (bus2.ready) break;
      @(negedge clk);
    end
    drive(0, 1'b1, 8'd57);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 8'd57);
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (got_bcd(0) !== 12'h000) $display("FAIL rstmid_bcd: got %h expected 000", got_bcd(0));
    else n_pass++;
    n_checks++;
    if (bus2.ready !== 1'b1 || bus2.done_tick !== 1'b0 || bus2.overflow !== 1'b0)
      $display("FAIL rstmid_flags: got ready %b done %b ovf %b expected 1 0 0",
               bus2.ready, bus2.done_tick, bus2.overflow);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    done_seen = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (bus2.done_tick) done_seen = 1'b1;
    end
    n_checks++;
    if (done_seen !== 1'b0) $display("FAIL rstmid_no_done: got %b expected 0", done_seen);
    else n_pass++;
    run_conv(0, 57, lat, seen);
    e = sb_q.pop_front();
    n_checks++;
    if (!seen || got_bcd(0) !== e.bcd)
      $display("FAIL rstmid_reconv: got %h expected %h (done seen %b)", got_bcd(0), e.bcd, seen);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int   dones;
    int   first_at;
    int   second_at;
    exp_t e;
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      if (bus2.ready) break;
      @(negedge clk);
    end
    drive(0, 1'b1, 8'd42);
    sb_q.push_back(model(42, 2));
    sb_q.push_back(model(42, 2));
    dones     = 0;
    first_at  = 0;
    second_at = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus2.done_tick) begin
        dones++;
        if (dones == 1) first_at = k;
        else second_at = k;
        e = sb_q.pop_front();
        n_checks++;
        if (got_bcd(0) !== e.bcd) $display("FAIL b2b_bcd %0d: got %h expected %h", dones, got_bcd(0), e.bcd);
        else n_pass++;
        if (dones == 2) begin
          drive(0, 1'b0, 8'd42);
          break;
        end
      end
    end
    drive(0, 1'b0, 8'd42);
    sb_q.delete();
    n_checks++;
    if (dones != 2 || second_at - first_at != 10)
      $display("FAIL b2b_period: got %0d dones, spacing %0d expected 2 dones, spacing 10",
               dones, second_at - first_at);
    else n_pass++;
  endtask

  task automatic test_chain;
    int   lat;
    bit   seen;
    int   down;
    int   bad;
    exp_t e;
    logic [11:0] d;
    bad = 0;
    for (int v = 0; v < 100; v++) begin
      run_conv(0, v, lat, seen);
      e = sb_q.pop_front();
      d = got_bcd(0);
      down = int'(d[7:4]) * 10 + int'(d[3:0]);
      n_checks++;
      if (!seen || down != v || bus2.overflow !== e.ovf) begin
        $display("FAIL chain %0d: got %0d ovf %b expected %0d ovf %b", v, down, bus2.overflow, v, e.ovf);
        bad++;
      end else n_pass++;
      if (bad > 5) break;
    end
  endtask

  initial begin
    test_reset();
    test_basic_84();
    test_values();
    test_digits3();
    test_mid_op_ignored();
    test_reset_mid();
    test_back_to_back();
    test_chain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
